// File: rtl/polar_sc_hard_decoder.sv
// Serial polar hard-decision decoder: deserialises an N-bit codeword, applies the
// inverse polar transform one butterfly stage per cycle, then extracts message bits.
module polar_sc_hard_decoder #(
  parameter int N    = 8,
  parameter int LOGN = 3,
  parameter int K    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         x_in,
  input  logic [N-1:0] f_inp,
  output logic         busy,
  output logic [N-1:0] u_out,
  output logic [K-1:0] msg_out,
  output logic         msg_valid,
  output logic         frozen_err,
  output logic         mask_err
);

  localparam int CW = LOGN + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [LOGN-1:0] STG_LAST = LOGN'(LOGN - 1);

  typedef enum logic [1:0] {IDLE, RECV, XFORM, EXTRACT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [LOGN-1:0] stage;
  logic [N-1:0]    v;
  logic [N-1:0]    mask;

  // Stage s pairs index i (bit s clear) with i + 2^s, i.e. i | 2^s.
  function automatic logic [N-1:0] butterfly(input logic [N-1:0] vin,
                                             input logic [LOGN-1:0] stg);
    logic [N-1:0] r;
    r = vin;
    for (int s = 0; s < LOGN; s++) begin
      if (stg == LOGN'(s)) begin
        for (int i = 0; i < N; i++) begin
          if (((i >> s) & 1) == 0) r[i] = vin[i] ^ vin[i | (1 << s)];
        end
      end
    end
    return r;
  endfunction

  // Message bit k comes from the k-th unfrozen index, lowest index first.
  function automatic logic [K-1:0] pick_msg(input logic [N-1:0] vin,
                                            input logic [N-1:0] m);
    logic [K-1:0] r;
    int           k;
    r = '0;
    k = 0;
    for (int j = 0; j < N; j++) begin
      if (!m[j]) begin
        if (k < K) r = r | (K'(vin[j]) << k);
        k++;
      end
    end
    return r;
  endfunction

  function automatic int count_zeros(input logic [N-1:0] m);
    int z;
    z = 0;
    for (int j = 0; j < N; j++) if (!m[j]) z++;
    return z;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ce) state_nxt = RECV;
      RECV:    if (ce && cnt == CNT_LAST) state_nxt = XFORM;
      XFORM:   if (stage == STG_LAST) state_nxt = EXTRACT;
      EXTRACT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == XFORM) || (state == EXTRACT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      stage      <= '0;
      v          <= '0;
      mask       <= '0;
      u_out      <= '0;
      msg_out    <= '0;
      msg_valid  <= 1'b0;
      frozen_err <= 1'b0;
      mask_err   <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ce) begin
            v    <= {v[N-2:0], x_in};
            mask <= f_inp;
            cnt  <= CW'(1);
          end
        end
        RECV: begin
          stage <= '0;
          if (ce) begin
            v   <= {v[N-2:0], x_in};
            cnt <= cnt + CW'(1);
          end
        end
        XFORM: begin
          v     <= butterfly(v, stage);
          stage <= stage + LOGN'(1);
        end
        EXTRACT: begin
          u_out      <= v;
          msg_out    <= pick_msg(v, mask);
          frozen_err <= |(v & mask);
          mask_err   <= (count_zeros(mask) != K);
          msg_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_sc_hard_decoder.sv
// Randomised and directed bench for polar_sc_hard_decoder, checked against a
// generator-matrix model of the polar transform.
module tb_polar_sc_hard_decoder;

  localparam int N = 8;
  localparam int LOGN = 3;
  localparam int K = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce = 1'b0;
  logic         x_in = 1'b0;
  logic [N-1:0] f_inp = '0;
  logic         busy;
  logic [N-1:0] u_out;
  logic [K-1:0] msg_out;
  logic         msg_valid;
  logic         frozen_err;
  logic         mask_err;

  int n_checks = 0;
  int n_fail = 0;

  polar_sc_hard_decoder #(.N(N), .LOGN(LOGN), .K(K)) dut (
    .clk(clk), .rst(rst), .ce(ce), .x_in(x_in), .f_inp(f_inp),
    .busy(busy), .u_out(u_out), .msg_out(msg_out), .msg_valid(msg_valid),
    .frozen_err(frozen_err), .mask_err(mask_err)
  );

  always #5 clk = ~clk;

  // u = x * G, G[j][i] = 1 iff index i is a bit-subset of index j.
  function automatic logic [N-1:0] model_u(input logic [N-1:0] x);
    logic [N-1:0] u;
    u = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if ((i & j) == i) u[i] = u[i] ^ x[j];
    return u;
  endfunction

  function automatic logic [K-1:0] model_msg(input logic [N-1:0] u, input logic [N-1:0] f);
    int q[$];
    logic [K-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (!f[i]) q.push_back(i);
    for (int k = 0; k < K; k++) if (k < q.size()) m[k] = u[q[k]];
    return m;
  endfunction

  function automatic logic model_mask_err(input logic [N-1:0] f);
    int z;
    z = 0;
    for (int i = 0; i < N; i++) if (!f[i]) z++;
    return z != K;
  endfunction

  // Drives N bits MSB first starting at the current (post-edge) time; returns
  // just after the edge that accepted the last bit with ce still as driven.
  task automatic drive_bits(input logic [N-1:0] x, input logic [N-1:0] f, input bit gaps);
    for (int b = N - 1; b >= 0; b--) begin
      if (gaps && b != N - 1) begin
        repeat ($urandom_range(0, 2)) begin
          ce = 1'b0;
          x_in = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      ce = 1'b1;
      x_in = x[b];
      if (b == N - 1) f_inp = f;
      @(posedge clk); #1;
      f_inp = N'($urandom);
    end
  endtask

  task automatic wait_valid(output int lat);
    ce = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!msg_valid && lat < 20);
  endtask

  task automatic check_result(input string name, input int lat, input logic [N-1:0] x,
                              input logic [N-1:0] f);
    logic [N-1:0] eu;
    eu = model_u(x);
    n_checks++;
    if (lat !== LOGN + 1) begin
      n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, LOGN + 1);
    end
    n_checks++;
    if (u_out !== eu) begin
      n_fail++; $display("FAIL %s u_out: got %h want %h", name, u_out, eu);
    end
    n_checks++;
    if (msg_out !== model_msg(eu, f)) begin
      n_fail++; $display("FAIL %s msg_out: got %b want %b", name, msg_out, model_msg(eu, f));
    end
    n_checks++;
    if (frozen_err !== (|(eu & f))) begin
      n_fail++; $display("FAIL %s frozen_err: got %b want %b", name, frozen_err, |(eu & f));
    end
    n_checks++;
    if (mask_err !== model_mask_err(f)) begin
      n_fail++; $display("FAIL %s mask_err: got %b want %b", name, mask_err, model_mask_err(f));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, msg_valid, frozen_err, mask_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset ctrl: got %b want 0000", {busy, msg_valid, frozen_err, mask_err});
    end
    n_checks++;
    if (u_out !== '0 || msg_out !== '0) begin
      n_fail++; $display("FAIL reset data: got u=%h m=%b want 0", u_out, msg_out);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] xs[5] = '{8'h55, 8'hFF, 8'hAA, 8'h01, 8'h00};
    logic [N-1:0] fs[5] = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h1F};
    int lat;
    for (int t = 0; t < 5; t++) begin
      drive_bits(xs[t], fs[t], 1'b0);
      wait_valid(lat);
      check_result($sformatf("directed_%h", xs[t]), lat, xs[t], fs[t]);
      @(posedge clk); #1;
      n_checks++;
      if (msg_valid !== 1'b0) begin
        n_fail++; $display("FAIL pulse_width_%0d: msg_valid got %b want 0", t, msg_valid);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (u_out !== 8'h00 || mask_err !== 1'b1) begin
      n_fail++; $display("FAIL hold: got u=%h mask_err=%b want 00/1", u_out, mask_err);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [N-1:0] x, f;
    int a, b;
    for (int t = 0; t < 30; t++) begin
      x = N'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom_range(0, N - 1);
        b = (a + $urandom_range(1, N - 1)) % N;
        f = ~((N'(1) << a) | (N'(1) << b));
      end else begin
        f = N'($urandom);
      end
      drive_bits(x, f, 1'b1);
      wait_valid(lat);
      check_result($sformatf("random_%0d", t), lat, x, f);
    end
  endtask

  task automatic test_reset_midframe();
    int pulses;
    logic [K-1:0] seen;
    drive_bits(8'hF0, 8'h3F, 1'b0);
    ce = 1'b0;
    drive_bits(8'h0F, 8'h3F, 1'b0);
    ce = 1'b0;
    // second call was 8 bits; replay with a reset after 4 bits of a new frame
    wait_valid(pulses);
    ce = 1'b1;
    f_inp = 8'h3F;
    for (int b = 0; b < 4; b++) begin
      x_in = 1'($urandom);
      @(posedge clk); #1;
    end
    ce = 1'b0;
    rst = 1'b1;
    #3;
    n_checks++;
    if (busy !== 1'b0 || u_out !== '0 || msg_out !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy=%b u=%h m=%b want 0", busy, u_out, msg_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_bits(8'hAA, 8'h3F, 1'b0);
    ce = 1'b0;
    pulses = 0;
    seen = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (msg_valid) begin
        pulses++;
        seen = msg_out;
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL midreset_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (seen !== 2'b11) begin
      n_fail++; $display("FAIL midreset_msg: got %b want 11", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] xa, xb, fa, fb;
    int lat;
    for (int t = 0; t < 6; t++) begin
      xa = N'($urandom);
      xb = N'($urandom);
      fa = (t == 0) ? 8'h3F : N'($urandom);
      fb = N'($urandom);
      drive_bits(xa, fa, 1'b0);
      for (int c = 0; c < LOGN + 1; c++) begin
        n_checks++;
        if (busy !== 1'b1 || msg_valid !== 1'b0) begin
          n_fail++; $display("FAIL b2b_busy_%0d_%0d: got busy=%b vld=%b want 1/0", t, c, busy, msg_valid);
        end
        ce = 1'b1;
        x_in = 1'($urandom);
        @(posedge clk); #1;
      end
      check_result($sformatf("b2b_a_%0d", t), LOGN + 1, xa, fa);
      n_checks++;
      if (msg_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_valid_%0d: got %b want 1", t, msg_valid);
      end
      drive_bits(xb, fb, 1'b0);
      wait_valid(lat);
      check_result($sformatf("b2b_b_%0d", t), lat, xb, fb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
